dds_param_receiver: RTL and testbench

//  Responder end of the REQ/ACK 4-phase handshake that master_start drives to pass chirp parameters
//  (DDS_freq, DDS_delta_freq, DDS_delta_rate) into the DDS clock domain. It synchronises REQ, captures
//  the parameter bus into a shadow bank and returns ACK. On a START pulse it copies the shadow into an

---
 rtl/dds_pkg.sv | 16 +
 rtl/sync_bit.sv | 23 ++
 rtl/dds_param_receiver.sv | 121 ++++++++++++
 tb/tb_dds_param_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, parameter-bank record and FSM state types for the DDS chirp parameter receiver.
package dds_pkg;

  localparam int unsigned FREQ_W = 48;
  localparam int unsigned RATE_W = 32;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] delta_freq;
    logic [RATE_W-1:0] delta_rate;
  } dds_param_t;

  typedef enum logic {H_IDLE, H_ACK} h_state_t;
  typedef enum logic {S_IDLE, S_RUN} s_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; the chain resets to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dds_param_receiver.sv
// REQ/ACK responder that captures chirp parameters into a shadow bank, plus a linear-FM
// frequency/phase generator that runs from the active bank loaded on START.
module dds_param_receiver
  import dds_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  output logic              ACK,
  input  logic [FREQ_W-1:0] DDS_freq,
  input  logic [FREQ_W-1:0] DDS_delta_freq,
  input  logic [RATE_W-1:0] DDS_delta_rate,
  input  logic              START,
  input  logic              STOP,
  output logic [FREQ_W-1:0] FREQ,
  output logic [FREQ_W-1:0] PHASE,
  output logic              VALID,
  output logic              NEW_PARAM
);

  logic w_req_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .i_clk(CLK),
    .i_rst(RESET),
    .i_d  (REQ),
    .o_q  (w_req_s)
  );

  h_state_t   r_h_state;
  dds_param_t r_shadow;
  logic       r_ack;
  logic       r_new_param;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_h_state   <= H_IDLE;
      r_shadow    <= '0;
      r_ack       <= 1'b0;
      r_new_param <= 1'b0;
    end else begin
      r_new_param <= 1'b0;
      case (r_h_state)
        H_IDLE: begin
          if (w_req_s) begin
            r_shadow    <= '{freq: DDS_freq, delta_freq: DDS_delta_freq,
                             delta_rate: DDS_delta_rate};
            r_new_param <= 1'b1;
            r_ack       <= 1'b1;
            r_h_state   <= H_ACK;
          end
        end
        H_ACK: begin
          if (!w_req_s) begin
            r_ack     <= 1'b0;
            r_h_state <= H_IDLE;
          end
        end
        default: r_h_state <= H_IDLE;
      endcase
    end
  end

  // Active bank keeps only the ramp terms; the running frequency itself lives in r_freq.
  s_state_t          r_s_state;
  logic [FREQ_W-1:0] r_act_dfreq;
  logic [RATE_W-1:0] r_act_rate;
  logic [RATE_W-1:0] r_rate_cnt;
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] r_phase;
  logic              r_valid;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s_state   <= S_IDLE;
      r_act_dfreq <= '0;
      r_act_rate  <= '0;
      r_rate_cnt  <= '0;
      r_freq      <= '0;
      r_phase     <= '0;
      r_valid     <= 1'b0;
    end else if (START) begin
      // Shadow is read before this edge's capture lands, so a same-edge capture waits for next START.
      r_act_dfreq <= r_shadow.delta_freq;
      r_act_rate  <= r_shadow.delta_rate;
      r_freq      <= r_shadow.freq;
      r_phase     <= '0;
      r_rate_cnt  <= '0;
      r_valid     <= 1'b1;
      r_s_state   <= S_RUN;
    end else if (r_s_state == S_RUN) begin
      if (STOP) begin
        r_freq    <= '0;
        r_phase   <= '0;
        r_valid   <= 1'b0;
        r_s_state <= S_IDLE;
      end else begin
        r_phase <= r_phase + r_freq;
        if (r_act_rate != '0) begin
          if (r_rate_cnt == r_act_rate - RATE_W'(1)) begin
            r_freq     <= r_freq + r_act_dfreq;
            r_rate_cnt <= '0;
          end else begin
            r_rate_cnt <= r_rate_cnt + RATE_W'(1);
          end
        end
      end
    end
  end

  assign ACK       = r_ack;
  assign NEW_PARAM = r_new_param;
  assign FREQ      = r_freq;
  assign PHASE     = r_phase;
  assign VALID     = r_valid;

endmodule

// File: tb/tb_dds_param_receiver.sv
// Directed, table-driven bench for dds_param_receiver: handshake timing, ramps, wrap and corner cases.
module tb_dds_param_receiver;
  import dds_pkg::*;

  localparam logic [47:0] FMAXM5 = 48'hFFFF_FFFF_FFFB;
  localparam logic [47:0] DNEG10 = 48'hFFFF_FFFF_FFF6;

  logic              CLK = 1'b0;
  logic              RESET, REQ, ACK, START, STOP, VALID, NEW_PARAM;
  logic [FREQ_W-1:0] DDS_freq, DDS_delta_freq, FREQ, PHASE;
  logic [RATE_W-1:0] DDS_delta_rate;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  dds_param_receiver #(
    .SYNC_STAGES(2)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ           (REQ),
    .ACK           (ACK),
    .DDS_freq      (DDS_freq),
    .DDS_delta_freq(DDS_delta_freq),
    .DDS_delta_rate(DDS_delta_rate),
    .START         (START),
    .STOP          (STOP),
    .FREQ          (FREQ),
    .PHASE         (PHASE),
    .VALID         (VALID),
    .NEW_PARAM     (NEW_PARAM)
  );

  typedef struct {
    logic [47:0] f;
    logic [47:0] d;
    logic [31:0] r;
    int          n;
    logic [47:0] ef;
    logic [47:0] ep;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic wait_ack(input logic lvl);
    int k;
    k = 0;
    while (ACK !== lvl && k < 10) begin
      step(1);
      k++;
    end
    if (ACK !== lvl) check("ack_timeout", {63'd0, ACK}, {63'd0, lvl});
  endtask

  task automatic handshake(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
    DDS_freq       = f;
    DDS_delta_freq = d;
    DDS_delta_rate = r;
    REQ            = 1'b1;
    wait_ack(1'b1);
    REQ = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step(1);
    START = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{f: 48'd1000, d: 48'd10, r: 32'd1, n: 0,  ef: 48'd1000, ep: 48'd0};
    vecs[1] = '{f: 48'd1000, d: 48'd10, r: 32'd1, n: 3,  ef: 48'd1030, ep: 48'd3030};
    vecs[2] = '{f: 48'd1000, d: 48'd10, r: 32'd3, n: 2,  ef: 48'd1000, ep: 48'd2000};
    vecs[3] = '{f: 48'd1000, d: 48'd10, r: 32'd3, n: 3,  ef: 48'd1010, ep: 48'd3000};
    vecs[4] = '{f: 48'd1000, d: 48'd10, r: 32'd3, n: 6,  ef: 48'd1020, ep: 48'd6030};
    vecs[5] = '{f: 48'd1000, d: 48'd10, r: 32'd0, n: 20, ef: 48'd1000, ep: 48'd20000};
    vecs[6] = '{f: FMAXM5,   d: 48'd10, r: 32'd1, n: 1,  ef: 48'd5,    ep: FMAXM5};
    vecs[7] = '{f: FMAXM5,   d: 48'd10, r: 32'd1, n: 2,  ef: 48'd15,   ep: 48'd0};
    vecs[8] = '{f: 48'd1000, d: DNEG10, r: 32'd2, n: 4,  ef: 48'd980,  ep: 48'd3980};

    RESET = 1'b1; REQ = 1'b0; START = 1'b0; STOP = 1'b0;
    DDS_freq = '0; DDS_delta_freq = '0; DDS_delta_rate = '0;
    step(2);
    RESET = 1'b0;
    step(1);
    check("rst_ack", {63'd0, ACK}, 64'd0);
    check("rst_valid", {63'd0, VALID}, 64'd0);
    check("rst_newp", {63'd0, NEW_PARAM}, 64'd0);
    check("rst_freq", {16'd0, FREQ}, 64'd0);
    check("rst_phase", {16'd0, PHASE}, 64'd0);

    // Handshake latency: ACK rises on the third edge after REQ, falls on the third after release.
    DDS_freq = 48'd1000; DDS_delta_freq = 48'd10; DDS_delta_rate = 32'd1;
    REQ = 1'b1;
    step(1); check("ack_rise_e1", {63'd0, ACK}, 64'd0);
    step(1); check("ack_rise_e2", {63'd0, ACK}, 64'd0);
    step(1); check("ack_rise_e3", {63'd0, ACK}, 64'd1);
    check("newp_pulse", {63'd0, NEW_PARAM}, 64'd1);
    step(1); check("newp_clear", {63'd0, NEW_PARAM}, 64'd0);
    check("ack_held", {63'd0, ACK}, 64'd1);
    REQ = 1'b0;
    step(2); check("ack_fall_e2", {63'd0, ACK}, 64'd1);
    step(1); check("ack_fall_e3", {63'd0, ACK}, 64'd0);
    pulse_start();
    check("shadow_freq", {16'd0, FREQ}, 64'd1000);
    check("start_valid", {63'd0, VALID}, 64'd1);
    pulse_stop();

    for (int i = 0; i < 9; i++) begin
      handshake(vecs[i].f, vecs[i].d, vecs[i].r);
      pulse_start();
      step(vecs[i].n);
      check($sformatf("vec%0d_freq", i), {16'd0, FREQ}, {16'd0, vecs[i].ef});
      check($sformatf("vec%0d_phase", i), {16'd0, PHASE}, {16'd0, vecs[i].ep});
      check($sformatf("vec%0d_valid", i), {63'd0, VALID}, 64'd1);
      pulse_stop();
    end

    // Capture while running leaves the sweep alone; a same-edge capture+START loads the old shadow.
    handshake(48'd1000, 48'd10, 32'd0);
    pulse_start();
    handshake(48'd5000, 48'd10, 32'd0);
    check("run_unaffected", {16'd0, FREQ}, 64'd1000);
    pulse_start();
    check("restart_new", {16'd0, FREQ}, 64'd5000);
    DDS_freq = 48'd7000;
    REQ = 1'b1;
    step(2);
    START = 1'b1;
    step(1);
    START = 1'b0;
    check("cap_start_old", {16'd0, FREQ}, 64'd5000);
    check("cap_start_ack", {63'd0, ACK}, 64'd1);
    REQ = 1'b0;
    wait_ack(1'b0);
    pulse_start();
    check("next_start_new", {16'd0, FREQ}, 64'd7000);

    pulse_stop();
    check("stop_valid", {63'd0, VALID}, 64'd0);
    check("stop_freq", {16'd0, FREQ}, 64'd0);
    check("stop_phase", {16'd0, PHASE}, 64'd0);
    pulse_stop();
    check("stop_idle", {63'd0, VALID}, 64'd0);

    START = 1'b1; STOP = 1'b1;
    step(1);
    START = 1'b0; STOP = 1'b0;
    check("startstop_valid", {63'd0, VALID}, 64'd1);
    check("startstop_freq", {16'd0, FREQ}, 64'd7000);
    step(1);
    check("startstop_phase", {16'd0, PHASE}, 64'd7000);

    // Reset during a running sweep with ACK high clears everything, including the shadow.
    REQ = 1'b1;
    step(3);
    check("pre_rst_ack", {63'd0, ACK}, 64'd1);
    RESET = 1'b1;
    step(1);
    check("mid_rst_ack", {63'd0, ACK}, 64'd0);
    check("mid_rst_valid", {63'd0, VALID}, 64'd0);
    check("mid_rst_freq", {16'd0, FREQ}, 64'd0);
    check("mid_rst_phase", {16'd0, PHASE}, 64'd0);
    RESET = 1'b0; REQ = 1'b0;
    step(3);
    pulse_start();
    check("post_rst_shadow", {16'd0, FREQ}, 64'd0);
    check("post_rst_valid", {63'd0, VALID}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
